// File: rtl/if_fetch_stage.sv
// if_fetch_stage: MIPS IF stage with PC register, imem interface, IF/ID register and a one-entry hold buffer.
// Optional FETCH_STATS_EN adds fetch_count/stall_count outputs.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] next_pc,
    input  logic        pc_write,
    input  logic        ifid_write,
    input  logic        ifid_flush,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] ifid_pc4,
    output logic [31:0] ifid_instr,
    output logic        ifid_valid
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
`endif
);
    typedef enum logic [1:0] {BOOT, FETCH, HELD} state_t;

    state_t      state_q;
    logic [31:0] pc_q, ifid_pc4_q, ifid_instr_q, hold_instr_q, hold_pc4_q;
    logic        ifid_valid_q, imem_req_q;
    logic        advance;

    // A stalled IF/ID means the PC must not move either, so both enables are required.
    assign advance    = pc_write & ifid_write;
    assign pc_plus4   = pc_q + PC_STEP;
    assign pc         = pc_q;
    assign imem_addr  = pc_q;
    assign imem_req   = imem_req_q;
    assign ifid_pc4   = ifid_pc4_q;
    assign ifid_instr = ifid_instr_q;
    assign ifid_valid = ifid_valid_q;

    // Fetch FSM: flush has priority, then per-state fetch/hold/release handling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= BOOT;
            pc_q         <= RESET_PC;
            ifid_pc4_q   <= '0;
            ifid_instr_q <= '0;
            ifid_valid_q <= 1'b0;
            hold_instr_q <= '0;
            hold_pc4_q   <= '0;
            imem_req_q   <= 1'b0;
        end else if (ifid_flush) begin
            state_q      <= FETCH;
            pc_q         <= next_pc;
            ifid_pc4_q   <= '0;
            ifid_instr_q <= '0;
            ifid_valid_q <= 1'b0;
            imem_req_q   <= 1'b1;
        end else begin
            case (state_q)
                BOOT: begin
                    state_q    <= FETCH;
                    imem_req_q <= 1'b1;
                end
                FETCH: begin
                    if (imem_ack && advance) begin
                        ifid_pc4_q   <= pc_plus4;
                        ifid_instr_q <= imem_rdata;
                        ifid_valid_q <= 1'b1;
                        pc_q         <= next_pc;
                    end else if (imem_ack) begin
                        hold_instr_q <= imem_rdata;
                        hold_pc4_q   <= pc_plus4;
                        state_q      <= HELD;
                        imem_req_q   <= 1'b0;
                    end else if (ifid_write) begin
                        ifid_instr_q <= '0;
                        ifid_valid_q <= 1'b0;
                    end
                end
                HELD: begin
                    if (advance) begin
                        ifid_pc4_q   <= hold_pc4_q;
                        ifid_instr_q <= hold_instr_q;
                        ifid_valid_q <= 1'b1;
                        pc_q         <= next_pc;
                        state_q      <= FETCH;
                        imem_req_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= BOOT;
                    imem_req_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_STATS_EN
    logic [31:0] fetch_count_q, stall_count_q;
    assign fetch_count = fetch_count_q;
    assign stall_count = stall_count_q;

    // Count real IF/ID loads and cycles spent waiting on memory or holding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            if (!ifid_flush && advance && ((state_q == FETCH && imem_ack) || state_q == HELD))
                fetch_count_q <= fetch_count_q + 32'd1;
            if ((state_q == FETCH && !imem_ack) || state_q == HELD)
                stall_count_q <= stall_count_q + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed self-checking bench for if_fetch_stage.
module tb_if_fetch_stage;
    logic        clk = 1'b0;
    logic        rst_n, pc_write, ifid_write, ifid_flush, imem_ack, seq, use_fix;
    logic [31:0] next_pc_r, fix_word;
    logic [31:0] next_pc, imem_addr, imem_rdata, pc, pc_plus4, ifid_pc4, ifid_instr;
    logic        imem_req, ifid_valid;
    int          n_checks = 0;
    int          n_fail = 0;
`ifdef FETCH_STATS_EN
    logic [31:0] fetch_count, stall_count;
`endif

    always #5 clk = ~clk;

    // Memory returns the bitwise complement of the address unless a fixed word is forced.
    assign next_pc    = seq ? pc_plus4 : next_pc_r;
    assign imem_rdata = use_fix ? fix_word : ~imem_addr;

    if_fetch_stage #(.RESET_PC(32'h00400000), .PC_STEP(32'd4)) dut (
        .clk(clk), .rst_n(rst_n), .next_pc(next_pc), .pc_write(pc_write),
        .ifid_write(ifid_write), .ifid_flush(ifid_flush), .imem_addr(imem_addr),
        .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pc(pc),
        .pc_plus4(pc_plus4), .ifid_pc4(ifid_pc4), .ifid_instr(ifid_instr),
        .ifid_valid(ifid_valid)
`ifdef FETCH_STATS_EN
        , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; pc_write = 1'b1; ifid_write = 1'b1; ifid_flush = 1'b0;
        imem_ack = 1'b1; seq = 1'b1; use_fix = 1'b0; next_pc_r = '0; fix_word = '0;
        #2 rst_n = 1'b0;
        step();
        n_checks++; if (pc !== 32'h00400000) begin n_fail++; $display("FAIL reset_pc: got %h want %h", pc, 32'h00400000); end
        n_checks++; if ({imem_req, ifid_valid} !== 2'b00) begin n_fail++; $display("FAIL reset_req_valid: got %b want 00", {imem_req, ifid_valid}); end
        n_checks++; if ({ifid_pc4, ifid_instr} !== 64'h0) begin n_fail++; $display("FAIL reset_ifid: got %h want 0", {ifid_pc4, ifid_instr}); end
        step();
        rst_n = 1'b1;
        #1;
        n_checks++; if ({imem_req, ifid_valid} !== 2'b00) begin n_fail++; $display("FAIL boot_cycle: got %b want 00", {imem_req, ifid_valid}); end
        step();
        n_checks++; if ({imem_req, ifid_valid, pc} !== {2'b10, 32'h00400000}) begin n_fail++; $display("FAIL first_fetch: got %h want %h", {imem_req, ifid_valid, pc}, {2'b10, 32'h00400000}); end
        step();
        n_checks++; if ({ifid_valid, ifid_pc4, ifid_instr, pc} !== {1'b1, 32'h00400004, 32'hFFBFFFFF, 32'h00400004}) begin n_fail++; $display("FAIL first_load: got %h want %h", {ifid_valid, ifid_pc4, ifid_instr, pc}, {1'b1, 32'h00400004, 32'hFFBFFFFF, 32'h00400004}); end
        step();
        n_checks++; if ({pc, ifid_pc4} !== {32'h00400008, 32'h00400008}) begin n_fail++; $display("FAIL back_to_back: got %h want %h", {pc, ifid_pc4}, {32'h00400008, 32'h00400008}); end
    endtask

    task automatic test_ack_wait();
        seq = 1'b0; next_pc_r = 32'h10; ifid_flush = 1'b1;
        step();
        ifid_flush = 1'b0;
        n_checks++; if ({pc, ifid_valid, ifid_instr, ifid_pc4, imem_req} !== {32'h10, 1'b0, 64'h0, 1'b1}) begin n_fail++; $display("FAIL flush_to_10: got %h", {pc, ifid_valid, ifid_instr, ifid_pc4, imem_req}); end
        imem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if ({pc, ifid_valid, ifid_instr, imem_req} !== {32'h10, 1'b0, 32'h0, 1'b1}) begin n_fail++; $display("FAIL ack_wait_%0d: got %h want %h", i, {pc, ifid_valid, ifid_instr, imem_req}, {32'h10, 1'b0, 32'h0, 1'b1}); end
        end
        imem_ack = 1'b1; seq = 1'b1;
        step();
        n_checks++; if ({pc, ifid_valid, ifid_instr, ifid_pc4} !== {32'h14, 1'b1, 32'hFFFFFFEF, 32'h14}) begin n_fail++; $display("FAIL ack_load: got %h want %h", {pc, ifid_valid, ifid_instr, ifid_pc4}, {32'h14, 1'b1, 32'hFFFFFFEF, 32'h14}); end
    endtask

    task automatic test_held();
        use_fix = 1'b1; fix_word = 32'h8C220004; pc_write = 1'b0;
        step();
        fix_word = 32'h0;
        n_checks++; if ({imem_req, pc, ifid_instr, ifid_pc4} !== {1'b0, 32'h14, 32'hFFFFFFEF, 32'h14}) begin n_fail++; $display("FAIL held_enter: got %h want %h", {imem_req, pc, ifid_instr, ifid_pc4}, {1'b0, 32'h14, 32'hFFFFFFEF, 32'h14}); end
        step();
        n_checks++; if ({imem_req, pc} !== {1'b0, 32'h14}) begin n_fail++; $display("FAIL held_stay: got %h want %h", {imem_req, pc}, {1'b0, 32'h14}); end
        pc_write = 1'b1;
        step();
        n_checks++; if ({ifid_valid, ifid_instr, ifid_pc4, pc, imem_req} !== {1'b1, 32'h8C220004, 32'h18, 32'h18, 1'b1}) begin n_fail++; $display("FAIL held_release: got %h want %h", {ifid_valid, ifid_instr, ifid_pc4, pc, imem_req}, {1'b1, 32'h8C220004, 32'h18, 32'h18, 1'b1}); end
        use_fix = 1'b0;
        step();
        n_checks++; if ({pc, ifid_instr} !== {32'h1C, 32'hFFFFFFE7}) begin n_fail++; $display("FAIL held_after: got %h want %h", {pc, ifid_instr}, {32'h1C, 32'hFFFFFFE7}); end
    endtask

    task automatic test_flush_held();
        use_fix = 1'b1; fix_word = 32'h12345678; pc_write = 1'b0;
        step();
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL fh_enter: got %b want 0", imem_req); end
        ifid_flush = 1'b1; seq = 1'b0; next_pc_r = 32'h100;
        step();
        ifid_flush = 1'b0; pc_write = 1'b1; seq = 1'b1; use_fix = 1'b0;
        n_checks++; if ({ifid_valid, ifid_instr, ifid_pc4, pc, imem_req} !== {1'b0, 64'h0, 32'h100, 1'b1}) begin n_fail++; $display("FAIL fh_flush: got %h", {ifid_valid, ifid_instr, ifid_pc4, pc, imem_req}); end
        step();
        n_checks++; if ({ifid_valid, ifid_instr, ifid_pc4, pc} !== {1'b1, 32'hFFFFFEFF, 32'h104, 32'h104}) begin n_fail++; $display("FAIL fh_refetch: got %h want %h", {ifid_valid, ifid_instr, ifid_pc4, pc}, {1'b1, 32'hFFFFFEFF, 32'h104, 32'h104}); end
    endtask

    task automatic test_flush_stall_wrap();
        pc_write = 1'b0; ifid_flush = 1'b1; seq = 1'b0; next_pc_r = 32'h200;
        step();
        n_checks++; if ({pc, ifid_valid, ifid_instr, imem_req} !== {32'h200, 1'b0, 32'h0, 1'b1}) begin n_fail++; $display("FAIL flush_stall: got %h", {pc, ifid_valid, ifid_instr, imem_req}); end
        next_pc_r = 32'hFFFFFFFC;
        step();
        n_checks++; if ({pc, pc_plus4} !== {32'hFFFFFFFC, 32'h0}) begin n_fail++; $display("FAIL wrap_plus4: got %h want %h", {pc, pc_plus4}, {32'hFFFFFFFC, 32'h0}); end
        ifid_flush = 1'b0; pc_write = 1'b1; seq = 1'b1;
        step();
        n_checks++; if ({ifid_valid, ifid_pc4, ifid_instr, pc} !== {1'b1, 32'h0, 32'h3, 32'h0}) begin n_fail++; $display("FAIL wrap_load: got %h want %h", {ifid_valid, ifid_pc4, ifid_instr, pc}, {1'b1, 32'h0, 32'h3, 32'h0}); end
    endtask

    task automatic test_async_reset();
        use_fix = 1'b1; fix_word = 32'hCAFEF00D; pc_write = 1'b0;
        step();
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if ({pc, imem_req, ifid_valid, ifid_instr} !== {32'h00400000, 2'b00, 32'h0}) begin n_fail++; $display("FAIL async_reset: got %h", {pc, imem_req, ifid_valid, ifid_instr}); end
        step();
        rst_n = 1'b1; pc_write = 1'b1; use_fix = 1'b0;
        step();
        step();
        n_checks++; if ({ifid_valid, ifid_instr, pc} !== {1'b1, 32'hFFBFFFFF, 32'h00400004}) begin n_fail++; $display("FAIL post_reset_fetch: got %h want %h", {ifid_valid, ifid_instr, pc}, {1'b1, 32'hFFBFFFFF, 32'h00400004}); end
    endtask

`ifdef FETCH_STATS_EN
    task automatic test_stats();
        logic [31:0] f0, s0;
        f0 = fetch_count; s0 = stall_count;
        for (int i = 0; i < 7; i++) begin
            imem_ack = !(i == 2 || i == 3);
            step();
        end
        imem_ack = 1'b1;
        n_checks++; if (fetch_count - f0 !== 32'd5) begin n_fail++; $display("FAIL fetch_count: got %0d want 5", fetch_count - f0); end
        n_checks++; if (stall_count - s0 !== 32'd2) begin n_fail++; $display("FAIL stall_count: got %0d want 2", stall_count - s0); end
    endtask
`endif

    initial begin
        test_reset();
        test_ack_wait();
        test_held();
        test_flush_held();
        test_flush_stall_wrap();
        test_async_reset();
`ifdef FETCH_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline: owns the PC register, drives instruction memory, and holds the IF/ID pipeline register.
- Produces pc_plus4 for input i0 of the PCSrc multiplexor and consumes that multiplexor's output as next_pc.
- Supports decode-stage stall, branch-flush and multi-cycle instruction memory through a small fetch FSM with a one-entry holding buffer.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- PC_STEP, 4, increment added to PC to form pc_plus4.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- next_pc  in  32  selected next PC (PCSrc mux output).
- pc_write  in  1  1 = PC may advance; 0 = hazard stall.
- ifid_write  in  1  1 = IF/ID may load; 0 = hold.
- ifid_flush  in  1  1 = squash IF/ID and redirect PC to next_pc.
- imem_addr  out  32  instruction address, equals current pc.
- imem_req  out  1  fetch request.
- imem_ack  in  1  imem_rdata is valid for imem_addr this cycle.
- imem_rdata  in  32  instruction word.
- pc  out  32  current PC register.
- pc_plus4  out  32  pc + PC_STEP, combinational, mod 2^32.
- ifid_pc4  out  32  registered pc_plus4 of the instruction in IF/ID.
- ifid_instr  out  32  registered instruction; 32'h0 (NOP) when invalid.
- ifid_valid  out  1  IF/ID holds a real instruction.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - pc=RESET_PC; ifid_pc4=0; ifid_instr=0; ifid_valid=0; imem_req=0; hold buffer empty; state=BOOT.
- Memory contract: combinational-ready memory. Data returned with imem_ack=1 belongs to the imem_addr of the same cycle. Address may change on any cycle; no outstanding transaction state exists.
- advance = pc_write & ifid_write.
- BOOT: imem_req=0. Next cycle goes to FETCH unconditionally. A BOOT-cycle flush only updates pc.
- FETCH: imem_req=1, imem_addr=pc.
  - ack & advance & !flush: IF/ID <= {pc_plus4, imem_rdata}, ifid_valid<=1, pc<=next_pc, stay FETCH. Back-to-back single-cycle fetches give 1 instruction/cycle.
  - ack & !advance & !flush: store imem_rdata and pc_plus4 in hold buffer; pc unchanged; IF/ID unchanged; go HELD.
  - !ack & !flush: pc and IF/ID unchanged. If ifid_write=1, load a bubble (ifid_valid<=0, ifid_instr<=0).
- HELD: imem_req=0; pc unchanged.
  - advance & !flush: IF/ID <= hold buffer, ifid_valid<=1, pc<=next_pc, go FETCH.
  - Otherwise stay in HELD.
- Flush (any state, highest priority):
  - ifid_valid<=0, ifid_instr<=0, ifid_pc4<=0; ack'd data and hold buffer discarded.
  - pc<=next_pc regardless of pc_write; state=FETCH.
- Flush and stall in the same cycle: flush wins.
- ifid_write=0 with pc_write=1 is treated as a stall (advance=0); pc does not advance without a slot in IF/ID.
- PC arithmetic is 32-bit unsigned and wraps (32'hFFFFFFFC + 4 = 0). No alignment checking.
- Reset asserted mid-fetch or in HELD: immediate return to reset values; in-flight data is lost.

Optional Feature:
- Macro FETCH_STATS_EN.
- When defined:
  - Adds output port fetch_count (32), incremented on every IF/ID load with ifid_valid<=1.
  - Adds output port stall_count (32), incremented on every cycle in FETCH with !ack or in HELD.
  - Both counters reset to 0 and wrap.
- When undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset with RESET_PC=32'h00400000, imem_ack tied 1, next_pc=pc_plus4 -> pc steps 0x00400000, 0x00400004, 0x00400008. IF/ID shows ifid_pc4=0x00400004 one cycle after the first fetch. ifid_valid=0 during the BOOT cycle.
- imem_ack low for 3 cycles at pc=0x10 -> pc held at 0x10; ifid_valid=0 (bubbles); instruction loaded on the ack cycle; pc -> 0x14.
- Ack of 0x8C220004 while pc_write=0 for 2 cycles -> state HELD, imem_req=0. Release -> ifid_instr=0x8C220004; pc advances exactly once.
- ifid_flush with next_pc=0x00000100 while in HELD -> hold buffer discarded; ifid_valid=0, ifid_instr=0; pc=0x100; next fetch at 0x100.
- Flush and pc_write=0 in the same cycle -> pc=next_pc, IF/ID squashed. Separately, pc=0xFFFFFFFC -> pc_plus4=0x00000000.
- With FETCH_STATS_EN: 5 fetches plus 2 ack-less cycles -> fetch_count=5, stall_count=2.
